riscv_mem_responder: RTL
========================

RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning 32-bit words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 0, range 0..15, meaning extra wait cycles before a response is presented.
REQ-003 SHALL have port clk  input  1  clock. All state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memreq_msg  input  67  VC memory request {type[66], addr[65:34], len[33:32], data[31:0]}.
REQ-006 SHALL have port memreq_val  input  1  request valid.
REQ-007 SHALL have port memreq_rdy  output  1  request ready.
REQ-008 SHALL have port memresp_msg  output  35  VC memory response {type[34], len[33:32], data[31:0]}.
REQ-009 SHALL have port memresp_val  output  1  response valid.
REQ-010 SHALL have port memresp_rdy  input  1  response ready; the core ties this to 1.
REQ-011 SHALL have port mem_err  output  1  sticky misalignment error (see Configuration).

Function
REQ-012 SHALL transfer a request on a cycle where memreq_val & memreq_rdy, and a response on a cycle where memresp_val & memresp_rdy.
REQ-013 SHALL use the FSM states IDLE, DELAY and RESP.
- IDLE, on accept: to DELAY if LATENCY>0, else to RESP.
- DELAY: counts LATENCY cycles, then to RESP.
- RESP, on response transfer: to IDLE, or stay in RESP if a new request is accepted in the same cycle.
REQ-014 SHALL drive memreq_rdy = (state==IDLE) | (state==RESP & memresp_rdy & LATENCY==0), giving one request per cycle at LATENCY 0.
REQ-015 SHALL assert memresp_val only in RESP, starting LATENCY+1 cycles after the accept edge, and hold it and memresp_msg stable until transfer.
REQ-016 SHALL set the response type equal to the request type and the response len equal to the request len.
REQ-017 SHALL decode len as 0=4 bytes, 1=1 byte, 2=2 bytes, 3=3 bytes.
REQ-018 SHALL address storage as word index addr[log2(MEM_WORDS)+1:2] (upper bits ignored, wrapping) and byte offset addr[1:0].
REQ-019 SHALL, on a read, return the addressed bytes right-justified and zero-extended in data; response data is 0 for writes.
REQ-020 SHALL, on a write, update only the len bytes starting at the byte offset, from data LSBs, on the accept edge.
REQ-021 SHALL present read data that reflects the memory at the accept edge, so a read accepted after a write sees the written value.
REQ-022 SHALL treat bytes beyond lane 3 (cross-word access) as dropped on write and zero on read when the check is disabled.

Reset
REQ-023 SHALL, during reset, force state IDLE, delay counter 0, memresp_val 0, memreq_rdy 0 and mem_err 0.
REQ-024 SHALL discard any in-flight request or pending response when reset is asserted mid-operation; no response is emitted for it.
REQ-025 SHALL NOT reset storage contents.
REQ-026 SHALL drive memreq_rdy 1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL use the macro RISCV_MEM_RESPONDER_ALIGN_CHECK_EN. When defined, an access is misaligned if len=2 with addr[0]=1, len=0 with addr[1:0]!=0, or len=3 with addr[1:0]>1. A misaligned access:
- sets mem_err (sticky until reset);
- has its write suppressed, or returns read data 0;
- still gets a normal response.
REQ-028 SHALL, when the macro is undefined, tie mem_err to 0 and follow REQ-022.

Structure
REQ-029 SHALL take message field widths, offsets and the type constants (VC_MEM_REQ_MSG_TYPE_READ/WRITE) from the shared vc-MemReqMsg.v / vc-MemRespMsg.v definitions. No local literals.
REQ-030 SHALL implement byte-lane write merge and read extract/zero-extend in one sub-module, riscv_mem_responder_bytelane.

Verification
REQ-031 SHALL cover: LATENCY=0; write addr 0x100 len0 data 0xDEADBEEF, then read 0x100 len0 -> resp data 0xDEADBEEF, val one cycle after each accept, back-to-back accepts.
REQ-032 SHALL cover: after REQ-031, read 0x101 len1 -> 0x000000BE; write 0x102 len2 data 0x1234, then read 0x100 len0 -> 0x1234BEEF.
REQ-033 SHALL cover: LATENCY=3; read accepted at cycle 10 -> memresp_val first high at cycle 14; memreq_rdy low in cycles 11-14.
REQ-034 SHALL cover: memresp_rdy held low for 5 cycles while in RESP -> memresp_msg stable, memreq_rdy 0, a single response on release.
REQ-035 SHALL cover: with ALIGN_CHECK_EN, write 0x103 len0 data 0xFFFFFFFF -> mem_err=1, word 0x100 unchanged; reset -> mem_err=0.
REQ-036 SHALL cover: reset asserted while in DELAY -> no memresp_val afterward, memreq_rdy=1 the cycle after reset drops.

Source files
------------

// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the riscv_mem_responder test memory.
// Message layout and type constants mirror vc-MemReqMsg.v / vc-MemRespMsg.v
// so every file takes field positions from one place.
package riscv_mem_responder_pkg;

  // Memory request message: {type, addr, len, data}
  localparam int VC_MEM_REQ_MSG_DATA_SZ  = 32;
  localparam int VC_MEM_REQ_MSG_LEN_SZ   = 2;
  localparam int VC_MEM_REQ_MSG_ADDR_SZ  = 32;
  localparam int VC_MEM_REQ_MSG_DATA_LSB = 0;
  localparam int VC_MEM_REQ_MSG_LEN_LSB  = VC_MEM_REQ_MSG_DATA_LSB + VC_MEM_REQ_MSG_DATA_SZ;
  localparam int VC_MEM_REQ_MSG_ADDR_LSB = VC_MEM_REQ_MSG_LEN_LSB + VC_MEM_REQ_MSG_LEN_SZ;
  localparam int VC_MEM_REQ_MSG_TYPE_BIT = VC_MEM_REQ_MSG_ADDR_LSB + VC_MEM_REQ_MSG_ADDR_SZ;
  localparam int VC_MEM_REQ_MSG_SZ       = VC_MEM_REQ_MSG_TYPE_BIT + 1;

  localparam logic VC_MEM_REQ_MSG_TYPE_READ  = 1'b0;
  localparam logic VC_MEM_REQ_MSG_TYPE_WRITE = 1'b1;

  // Memory response message: {type, len, data}
  localparam int VC_MEM_RESP_MSG_DATA_SZ  = 32;
  localparam int VC_MEM_RESP_MSG_LEN_SZ   = 2;
  localparam int VC_MEM_RESP_MSG_DATA_LSB = 0;
  localparam int VC_MEM_RESP_MSG_LEN_LSB  = VC_MEM_RESP_MSG_DATA_LSB + VC_MEM_RESP_MSG_DATA_SZ;
  localparam int VC_MEM_RESP_MSG_TYPE_BIT = VC_MEM_RESP_MSG_LEN_LSB + VC_MEM_RESP_MSG_LEN_SZ;
  localparam int VC_MEM_RESP_MSG_SZ       = VC_MEM_RESP_MSG_TYPE_BIT + 1;

  localparam logic VC_MEM_RESP_MSG_TYPE_READ  = 1'b0;
  localparam logic VC_MEM_RESP_MSG_TYPE_WRITE = 1'b1;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Byte-enable pattern for a len field anchored at lane 0 (len 0 means a full word)
  function automatic logic [3:0] len_to_mask(input logic [1:0] len);
    case (len)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Natural-alignment rule: halfwords on even bytes, words on word boundaries,
  // 3-byte accesses must still fit inside the word
  function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
    return ((len == 2'd2) && off[0])
        || ((len == 2'd0) && (off != 2'd0))
        || ((len == 2'd3) && (off > 2'd1));
  endfunction

endpackage

// File: rtl/riscv_mem_responder_bytelane.sv
// Byte-lane steering for the memory responder: merges write bytes into the
// addressed word and extracts read bytes right-justified and zero-extended.
// Bytes that would spill past lane 3 are dropped on write and read as zero.
module riscv_mem_responder_bytelane
  import riscv_mem_responder_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic [31:0] word_out,
  output logic [31:0] rdata
);

  logic [3:0]  len_mask;
  logic [3:0]  lane_mask;
  logic [31:0] wshift;
  logic [31:0] rshift;
  logic [31:0] wbits;
  logic [31:0] rbits;

  // Shift data to/from the byte offset and mask with the per-lane enables
  always_comb begin
    len_mask  = len_to_mask(len);
    lane_mask = len_mask << offset;
    wshift    = wdata << {offset, 3'b000};
    rshift    = word_in >> {offset, 3'b000};
    wbits     = '0;
    rbits     = '0;
    for (int i = 0; i < 4; i++) begin
      wbits[8*i +: 8] = {8{lane_mask[i]}};
      rbits[8*i +: 8] = {8{len_mask[i]}};
    end
    word_out = (word_in & ~wbits) | (wshift & wbits);
    rdata    = rshift & rbits;
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Single-ported test memory speaking the vc memory request/response protocol.
// Optional feature macro: RISCV_MEM_RESPONDER_ALIGN_CHECK_EN enables the
// misalignment check and the sticky mem_err flag; without it mem_err is 0.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 0
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [VC_MEM_REQ_MSG_SZ-1:0]  memreq_msg,
  input  logic                          memreq_val,
  output logic                          memreq_rdy,
  output logic [VC_MEM_RESP_MSG_SZ-1:0] memresp_msg,
  output logic                          memresp_val,
  input  logic                          memresp_rdy,
  output logic                          mem_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic                              req_type;
  logic [VC_MEM_REQ_MSG_ADDR_SZ-1:0] req_addr;
  logic [VC_MEM_REQ_MSG_LEN_SZ-1:0]  req_len;
  logic [VC_MEM_REQ_MSG_DATA_SZ-1:0] req_data;
  logic [IDX_W-1:0]                  word_idx;
  logic [1:0]                        byte_off;
  logic                              unused_addr_hi;

  assign req_type = memreq_msg[VC_MEM_REQ_MSG_TYPE_BIT];
  assign req_addr = memreq_msg[VC_MEM_REQ_MSG_ADDR_LSB +: VC_MEM_REQ_MSG_ADDR_SZ];
  assign req_len  = memreq_msg[VC_MEM_REQ_MSG_LEN_LSB +: VC_MEM_REQ_MSG_LEN_SZ];
  assign req_data = memreq_msg[VC_MEM_REQ_MSG_DATA_LSB +: VC_MEM_REQ_MSG_DATA_SZ];
  assign word_idx = req_addr[IDX_W+1:2];
  assign byte_off = req_addr[1:0];
  assign unused_addr_hi = ^req_addr[VC_MEM_REQ_MSG_ADDR_SZ-1:IDX_W+2];

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] cur_word;
  logic [31:0] merged_word;
  logic [31:0] lane_rdata;

  assign cur_word = mem[word_idx];

  riscv_mem_responder_bytelane u_bytelane (
    .word_in  (cur_word),
    .offset   (byte_off),
    .len      (req_len),
    .wdata    (req_data),
    .word_out (merged_word),
    .rdata    (lane_rdata)
  );

  state_t                        state;
  logic [3:0]                    delay_cnt;
  logic [VC_MEM_RESP_MSG_SZ-1:0] resp_msg_q;
  logic [VC_MEM_RESP_MSG_SZ-1:0] resp_next;
  logic                          misaligned;
  logic                          is_read;
  logic                          req_go;
  logic                          resp_go;

`ifdef RISCV_MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(req_len, byte_off);
`else
  assign misaligned = 1'b0;
`endif

  assign is_read     = (req_type == VC_MEM_REQ_MSG_TYPE_READ);
  assign memreq_rdy  = ~reset & ((state == IDLE)
                     | ((state == RESP) & memresp_rdy & (LATENCY == 0)));
  assign memresp_val = ~reset & (state == RESP);
  assign memresp_msg = resp_msg_q;
  assign req_go      = memreq_val & memreq_rdy;
  assign resp_go     = memresp_val & memresp_rdy;

  // Build the response at accept time so reads see memory as of the accept edge
  always_comb begin
    resp_next = '0;
    resp_next[VC_MEM_RESP_MSG_TYPE_BIT] = req_type;
    resp_next[VC_MEM_RESP_MSG_LEN_LSB +: VC_MEM_RESP_MSG_LEN_SZ] = req_len;
    resp_next[VC_MEM_RESP_MSG_DATA_LSB +: VC_MEM_RESP_MSG_DATA_SZ] =
      (is_read & ~misaligned) ? lane_rdata : '0;
  end

  // Storage is never reset; writes land on the accept edge unless suppressed
  always_ff @(posedge clk) begin
    if (req_go && (req_type == VC_MEM_REQ_MSG_TYPE_WRITE) && !misaligned) begin
      mem[word_idx] <= merged_word;
    end
  end

  // Hold the captured response until it transfers
  always_ff @(posedge clk) begin
    if (req_go) begin
      resp_msg_q <= resp_next;
    end
  end

  // Handshake FSM: accept, optionally wait LATENCY cycles, then present
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      delay_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_go) begin
            if (LATENCY > 0) begin
              state     <= DELAY;
              delay_cnt <= 4'(LATENCY - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        DELAY: begin
          if (delay_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            delay_cnt <= delay_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_go) begin
            state <= req_go ? RESP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RISCV_MEM_RESPONDER_ALIGN_CHECK_EN
  logic err_q;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (req_go && misaligned) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q & ~reset;
`else
  assign mem_err = 1'b0;
`endif

endmodule
